// File: rtl/mc_control_if.sv
// Control/status bundle between the multi-cycle controller (master) and its datapath (slave).
interface mc_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [10:0]      opcode;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic [2:0]       state;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             alusrc;
    logic             reg2loc;
    logic             mem2reg;
    logic [3:0]       aluop;
    logic [2:0]       signop;
    logic             done;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, imem_ready, dmem_ready,
        output state, ir_write, pc_write, pc_src, regwrite, memread, memwrite,
               alusrc, reg2loc, mem2reg, aluop, signop, done, fault, retired
    );

    modport slave (
        output opcode, zero, imem_ready, dmem_ready,
        input  state, ir_write, pc_write, pc_src, regwrite, memread, memwrite,
               alusrc, reg2loc, mem2reg, aluop, signop, done, fault, retired
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle LEGv8-subset controller: FETCH/DECODE/EXEC/MEM/WB with ready timeouts and sticky fault.
// Define MC_CONTROL_RETIRE_CNT_EN to build the retired-instruction counter.
module mc_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input logic          CLK,
    input logic          resetl,
    mc_control_if.master bus
);
    localparam int unsigned     WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        OP_LDUR, OP_STUR, OP_AND, OP_ORR, OP_ADD, OP_SUB,
        OP_ADDI, OP_SUBI, OP_MOVZ, OP_B, OP_CBZ, OP_BAD
    } op_e;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              run_q;
    op_e               op;
    logic [3:0]        alu_sel;
    logic [2:0]        sop_sel;
    logic              asrc_sel;

    always_comb begin
        op = OP_BAD;
        casez (bus.opcode)
            11'b??111000010: op = OP_LDUR;
            11'b??111000000: op = OP_STUR;
            11'b?0001010???: op = OP_AND;
            11'b?0101010???: op = OP_ORR;
            11'b?0?01011???: op = OP_ADD;
            11'b?1?01011???: op = OP_SUB;
            11'b?0?10001???: op = OP_ADDI;
            11'b?1?10001???: op = OP_SUBI;
            11'b110100101??: op = OP_MOVZ;
            11'b?00101?????: op = OP_B;
            11'b?011010????: op = OP_CBZ;
            default:         op = OP_BAD;
        endcase
    end

    always_comb begin
        alu_sel  = 4'b0000;
        sop_sel  = 3'b000;
        asrc_sel = 1'b0;
        case (op)
            OP_LDUR, OP_STUR: begin alu_sel = 4'b0010; sop_sel = 3'b001; asrc_sel = 1'b1; end
            OP_ADD:           alu_sel = 4'b0010;
            OP_SUB:           alu_sel = 4'b0110;
            OP_AND:           alu_sel = 4'b0000;
            OP_ORR:           alu_sel = 4'b0001;
            OP_ADDI:          begin alu_sel = 4'b0010; asrc_sel = 1'b1; end
            OP_SUBI:          begin alu_sel = 4'b0110; asrc_sel = 1'b1; end
            OP_MOVZ:          begin alu_sel = 4'b0111; sop_sel = {1'b1, bus.opcode[1:0]}; asrc_sel = 1'b1; end
            OP_B:             sop_sel = 3'b010;
            OP_CBZ:           begin alu_sel = 4'b0111; sop_sel = 3'b011; end
            default:          ;
        endcase
    end

    // run_q holds the FSM idle for the cycle after reset release, so FETCH starts on the first edge.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= FETCH;
            wait_q  <= '0;
            run_q   <= 1'b0;
        end else if (!run_q) begin
            run_q <= 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_ready)        state_q <= DECODE;
                    else if (wait_q == WAIT_MAX) state_q <= FAULT;
                    else                       wait_q  <= wait_q + 1'b1;
                end
                DECODE: begin
                    if (op == OP_BAD) state_q <= FAULT;
                    else              state_q <= EXEC;
                end
                EXEC: begin
                    wait_q <= '0;
                    if (op == OP_B || op == OP_CBZ)         state_q <= FETCH;
                    else if (op == OP_LDUR || op == OP_STUR) state_q <= MEM;
                    else                                    state_q <= WB;
                end
                MEM: begin
                    if (bus.dmem_ready) begin
                        wait_q <= '0;
                        if (op == OP_LDUR) state_q <= WB;
                        else               state_q <= FETCH;
                    end else if (wait_q == WAIT_MAX) begin
                        state_q <= FAULT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                WB: begin
                    wait_q  <= '0;
                    state_q <= FETCH;
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= FAULT;
            endcase
        end
    end

    // Strobes decode from state_q plus the ready/zero inputs so handshakes complete in the same cycle.
    always_comb begin
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_src   = 1'b0;
        bus.regwrite = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.alusrc   = 1'b0;
        bus.reg2loc  = 1'b0;
        bus.mem2reg  = 1'b0;
        bus.aluop    = 4'b0000;
        bus.signop   = 3'b000;
        bus.done     = 1'b0;
        bus.fault    = 1'b0;
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    bus.memread  = 1'b1;
                    bus.ir_write = bus.imem_ready;
                end
                DECODE: begin
                    bus.reg2loc = (op == OP_STUR) || (op == OP_CBZ);
                    bus.signop  = sop_sel;
                end
                EXEC: begin
                    bus.reg2loc = (op == OP_STUR) || (op == OP_CBZ);
                    bus.signop  = sop_sel;
                    bus.aluop   = alu_sel;
                    bus.alusrc  = asrc_sel;
                    if (op == OP_B || op == OP_CBZ) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = (op == OP_B) ? 1'b1 : bus.zero;
                        bus.done     = 1'b1;
                    end
                end
                MEM: begin
                    bus.signop   = sop_sel;
                    bus.memread  = (op == OP_LDUR);
                    bus.memwrite = (op == OP_STUR);
                    if (op == OP_STUR && bus.dmem_ready) begin
                        bus.pc_write = 1'b1;
                        bus.done     = 1'b1;
                    end
                end
                WB: begin
                    bus.signop   = sop_sel;
                    bus.regwrite = 1'b1;
                    bus.mem2reg  = (op == OP_LDUR);
                    bus.pc_write = 1'b1;
                    bus.done     = 1'b1;
                end
                FAULT:   bus.fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

`ifdef MC_CONTROL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl)       retired_q <= '0;
        else if (bus.done) retired_q <= retired_q + 1'b1;
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus randomized instructions against a trace model.
`timescale 1ns/1ps
module tb_mc_control;
    localparam int unsigned TO = 15;
    localparam int unsigned CW = 4;

    // Instruction classes in decode priority order; index 11 means unsupported.
    localparam logic [10:0] MASK_T [12] = '{
        11'b00111111111, 11'b00111111111, 11'b01111111000, 11'b01111111000,
        11'b01011111000, 11'b01011111000, 11'b01011111000, 11'b01011111000,
        11'b11111111100, 11'b01111100000, 11'b01111110000, 11'b00000000000};
    localparam logic [10:0] VAL_T [12] = '{
        11'b00111000010, 11'b00111000000, 11'b00001010000, 11'b00101010000,
        11'b00001011000, 11'b01001011000, 11'b00010001000, 11'b01010001000,
        11'b11010010100, 11'b00010100000, 11'b00110100000, 11'b00000000000};
    localparam logic [3:0] ALU_T [12] = '{
        4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0110,
        4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0111, 4'b0000};
    localparam logic ASRC_T [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic CLK = 1'b0;
    logic resetl = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [CW-1:0] exp_ret = '0;

    mc_control_if #(.CNT_W(CW)) bus ();

    mc_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK    (CLK),
        .resetl (resetl),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    function automatic int classify(input logic [10:0] opc);
        for (int i = 0; i < 11; i++)
            if ((opc & MASK_T[i]) == VAL_T[i]) return i;
        return 11;
    endfunction

    function automatic logic [2:0] sel_signop(input int c, input logic [10:0] opc);
        case (c)
            0, 1:    return 3'b001;
            8:       return {1'b1, opc[1:0]};
            9:       return 3'b010;
            10:      return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // {state, ir_write, pc_write, pc_src, regwrite, memread, memwrite, alusrc, reg2loc, mem2reg, aluop, signop, done, fault}
    function automatic logic [20:0] obs();
        return {bus.state, bus.ir_write, bus.pc_write, bus.pc_src, bus.regwrite, bus.memread,
                bus.memwrite, bus.alusrc, bus.reg2loc, bus.mem2reg, bus.aluop, bus.signop,
                bus.done, bus.fault};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [20:0] e);
        #1;
        cmp(tag, 32'(obs()), 32'(e));
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset(input string tag);
        resetl = 1'b0;
        step({tag, " in_reset"}, '0);
        exp_ret = '0;
        cmp({tag, " retired_reset"}, 32'(bus.retired), 32'(exp_ret));
        resetl = 1'b1;
        step({tag, " release_idle"}, '0);
    endtask

    task automatic retire(input string tag);
`ifdef MC_CONTROL_RETIRE_CNT_EN
        exp_ret = exp_ret + 1'b1;
`endif
        cmp({tag, " retired"}, 32'(bus.retired), 32'(exp_ret));
    endtask

    task automatic fault_hold(input string tag);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            bus.zero       = 1'($urandom);
            step({tag, " fault"}, {3'd7, 9'b0, 4'd0, 3'd0, 1'b0, 1'b1});
        end
        cmp({tag, " retired_in_fault"}, 32'(bus.retired), 32'(exp_ret));
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset({tag, " post_fault"});
    endtask

    // Walks one instruction through the expected per-cycle trace; rst_mem >= 0 pulses reset in that MEM cycle.
    task automatic run_instr(input string tag, input logic [10:0] opc, input int unsigned di,
                             input int unsigned dd, input logic z, input int rst_mem);
        int c;
        logic ld, st, br, cb, r2, fin;
        logic [2:0] so;
        c  = classify(opc);
        ld = (c == 0);
        st = (c == 1);
        br = (c == 9);
        cb = (c == 10);
        r2 = st || cb;
        so = sel_signop(c, opc);

        bus.opcode     = 11'($urandom);
        bus.zero       = z;
        bus.dmem_ready = 1'b0;
        for (int unsigned k = 0; k <= di && k <= TO; k++) begin
            bus.imem_ready = (k == di);
            step({tag, " fetch"}, {3'd0, (k == di), 4'b0001, 4'b0000, 4'd0, 3'd0, 2'b00});
        end
        bus.imem_ready = 1'($urandom);
        if (di > TO) begin
            fault_hold({tag, " imem_timeout"});
            return;
        end

        bus.opcode = opc;
        step({tag, " decode"}, {3'd1, 7'b0, r2, 1'b0, 4'd0, so, 2'b00});
        if (c == 11) begin
            fault_hold({tag, " bad_opcode"});
            return;
        end

        step({tag, " exec"}, {3'd2, 1'b0, br || cb, br || (cb && z), 3'b000, ASRC_T[c], r2, 1'b0,
                              ALU_T[c], so, br || cb, 1'b0});
        if (br || cb) begin
            retire(tag);
            return;
        end

        if (ld || st) begin
            for (int unsigned k = 0; k <= dd && k <= TO; k++) begin
                bus.dmem_ready = (k == dd);
                fin = (k == dd);
                if (int'(k) == rst_mem) begin
                    #1;
                    cmp({tag, " mem_before_reset"}, 32'(obs()),
                        32'({3'd3, 1'b0, 1'b0, 1'b0, 1'b0, ld, st, 3'b000, 4'd0, so, 2'b00}));
                    #2;
                    resetl = 1'b0;
                    #1;
                    cmp({tag, " async_reset_outputs"}, 32'(obs()), 32'd0);
                    exp_ret = '0;
                    cmp({tag, " async_reset_retired"}, 32'(bus.retired), 32'(exp_ret));
                    @(negedge CLK);
                    bus.dmem_ready = 1'b0;
                    resetl = 1'b1;
                    step({tag, " release_idle"}, '0);
                    return;
                end
                step({tag, " mem"}, {3'd3, 1'b0, st && fin, 1'b0, 1'b0, ld, st, 3'b000,
                                     4'd0, so, st && fin, 1'b0});
            end
            bus.dmem_ready = 1'b0;
            if (dd > TO) begin
                fault_hold({tag, " dmem_timeout"});
                return;
            end
            if (st) begin
                retire(tag);
                return;
            end
        end

        step({tag, " wb"}, {3'd4, 4'b0101, 4'b0000, ld, 4'd0, so, 2'b10});
        retire(tag);
    endtask

    logic [10:0]  r_opc;
    logic [10:0]  r_fill;
    int unsigned  r_pick, r_di, r_dd;

    initial begin
        bus.opcode     = '0;
        bus.zero       = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(negedge CLK);
        do_reset("startup");

        run_instr("addreg",      11'b10001011000, 0, 0, 1'b0, -1);
        run_instr("ldur_dd3",    11'b11111000010, 0, 3, 1'b0, -1);
        run_instr("cbz_taken",   11'b10110100000, 0, 0, 1'b1, -1);
        run_instr("cbz_not",     11'b10110100000, 0, 0, 1'b0, -1);
        run_instr("b",           11'b00010100000, 1, 0, 1'b0, -1);
        run_instr("stur",        11'b11111000000, 0, 0, 1'b0, -1);
        run_instr("movz",        11'b11010010111, 0, 0, 1'b0, -1);
        run_instr("orr",         11'b10101010000, 2, 0, 1'b0, -1);
        run_instr("subimm",      11'b11010001000, 0, 0, 1'b0, -1);
        run_instr("addi_di15",   11'b10010001000, TO, 0, 1'b0, -1);
        run_instr("ldur_dd15",   11'b11111000010, 0, TO, 1'b0, -1);
        run_instr("imem_stuck",  11'b10001011000, TO + 1, 0, 1'b0, -1);
        run_instr("stur_dmem_to", 11'b11111000000, 0, TO + 1, 1'b0, -1);
        run_instr("bad_opcode",  11'b00000000000, 0, 0, 1'b0, -1);
        run_instr("stur_rst",    11'b11111000000, 0, 8, 1'b0, 2);

        for (int i = 0; i < 17; i++)
            run_instr("b_wrap", 11'b00010100000, 0, 0, 1'b0, -1);

        for (int n = 0; n < 80; n++) begin
            r_pick = $urandom_range(0, 15);
            r_fill = 11'($urandom);
            if (r_pick == 15) r_opc = r_fill;
            else              r_opc = VAL_T[r_pick % 11] | (r_fill & ~MASK_T[r_pick % 11]);
            r_di = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, 3);
            r_dd = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, 3);
            run_instr("rand", r_opc, r_di, r_dd, 1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
